// File: rtl/matrix_bank.sv
// Multi-slot N x N matrix register file: whole writes, row-streamed loads with atomic commit,
// per-slot clear, registered read. Optional TRANSPOSE_EN adds wr_transpose for transposed stores.
module matrix_bank #(
    parameter int N       = 4,
    parameter int W       = 16,
    parameter int SLOT_AW = 2
) (
    input  logic                 CLK,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [SLOT_AW-1:0]   wr_slot,
    input  logic [N*N*W-1:0]     wr_data,
`ifdef TRANSPOSE_EN
    input  logic                 wr_transpose,
`endif
    input  logic                 clr_en,
    input  logic [SLOT_AW-1:0]   clr_slot,
    input  logic                 row_valid,
    output logic                 row_ready,
    input  logic [N*W-1:0]       row_data,
    input  logic [SLOT_AW-1:0]   row_slot,
    input  logic                 row_abort,
    output logic                 load_done,
    input  logic [SLOT_AW-1:0]   rd_slot,
    output logic [N*N*W-1:0]     rd_matrix
);
    // state  | meaning
    // IDLE   | waiting for row 0 of a new stream
    // FILL   | collecting rows 1..N-1 into the shadow buffer
    // COMMIT | shadow buffer written to the latched slot, load_done high

    localparam int ROW_W = N * W;
    localparam int MAT_W = N * N * W;
    localparam int SLOTS = 1 << SLOT_AW;
    localparam int CNT_W = $clog2(N);

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [SLOT_AW-1:0]   slot_q;
    logic [MAT_W-1:0]     shadow_q;
    logic [MAT_W-1:0]     mem [SLOTS];
    logic                 accept;
    logic                 commit;
    logic                 tr_row;
    logic [MAT_W-1:0]     wr_word;

`ifdef TRANSPOSE_EN
    logic tr_q;

    function automatic logic [MAT_W-1:0] transpose(input logic [MAT_W-1:0] m);
        logic [MAT_W-1:0] t;
        t = '0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                t[(r*N+c)*W +: W] = m[(c*N+r)*W +: W];
        return t;
    endfunction

    // Orientation is fixed by row 0 and held for the rest of the stream.
    assign tr_row  = (state_q == IDLE) ? wr_transpose : tr_q;
    assign wr_word = wr_transpose ? transpose(wr_data) : wr_data;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            tr_q <= 1'b0;
        else if (accept && state_q == IDLE)
            tr_q <= wr_transpose;
    end
`else
    assign tr_row  = 1'b0;
    assign wr_word = wr_data;
`endif

    assign row_ready = (state_q != COMMIT);
    assign load_done = (state_q == COMMIT);
    assign commit    = (state_q == COMMIT);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!row_abort && row_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(1);
                    state_d = FILL;
                end
            end
            FILL: begin
                if (row_abort) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (row_valid) begin
                    accept = 1'b1;
                    if (cnt_q == CNT_W'(N-1)) begin
                        cnt_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // cnt_q is 0 in IDLE, so row 0 lands in the same place as any other row.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            shadow_q <= '0;
            slot_q   <= '0;
        end else if (accept) begin
            if (state_q == IDLE)
                slot_q <= row_slot;
            if (tr_row) begin
                for (int c = 0; c < N; c++)
                    shadow_q[(c*N+int'(cnt_q))*W +: W] <= row_data[c*W +: W];
            end else begin
                shadow_q[int'(cnt_q)*ROW_W +: ROW_W] <= row_data;
            end
        end
    end

    // Per-slot priority: clear beats commit beats whole write.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SLOTS; i++)
                mem[i] <= '0;
            rd_matrix <= '0;
        end else begin
            rd_matrix <= mem[rd_slot];
            for (int i = 0; i < SLOTS; i++) begin
                if (clr_en && clr_slot == SLOT_AW'(i))
                    mem[i] <= '0;
                else if (commit && slot_q == SLOT_AW'(i))
                    mem[i] <= shadow_q;
                else if (wr_en && wr_slot == SLOT_AW'(i))
                    mem[i] <= wr_word;
            end
        end
    end

endmodule
